cla_restoring_divider: RTL
==========================

# cla_restoring_divider

Multi-cycle unsigned restoring divider, WIDTH bits by default 4. It is the inverse arithmetic partner of the 4-bit carry-lookahead adder. Each iteration performs one trial subtraction through a carry-lookahead subtractor (A + ~B + 1) and either keeps or restores the partial remainder. It sits beside the adder in the arithmetic datapath and uses a start/done handshake.

## Interface
- WIDTH, 4: operand, quotient and remainder width (≥2).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- Dividend  input  WIDTH  numerator, captured when start is accepted.
- Divisor  input  WIDTH  denominator, captured when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- Quotient  output  WIDTH  result.
- Remainder  output  WIDTH  result.
- DivByZero  output  1  flag for the last operation; tied to 0 when the feature is compiled out.

## Operation
- States and transitions:
  - IDLE: busy=0. On start, go to RUN.
  - RUN: busy=1, runs for WIDTH cycles, then goes to DONE.
  - DONE: busy=0, done=1 for one cycle. Goes to IDLE, or to RUN if start is high.
- Start acceptance:
  - start is accepted in IDLE or DONE.
  - On acceptance: Q shift register ← Dividend, D ← Divisor, R ← 0, step counter ← WIDTH-1.
- RUN step:
  - trial = {R[WIDTH-1:0], Q[WIDTH-1]} − {1'b0, D}, computed at WIDTH+1 bits by the CLA subtractor.
  - If there is no borrow (trial ≥ 0): R ← trial, Q ← {Q[WIDTH-2:0], 1}.
  - Otherwise: R ← {R[WIDTH-1:0], Q[WIDTH-1]}, Q ← {Q[WIDTH-2:0], 0}.
- Results:
  - Quotient = Q and Remainder = R[WIDTH-1:0], held stable from the done cycle until the next accepted start.
  - Invariant: Dividend = Quotient·Divisor + Remainder, with Remainder < Divisor when Divisor ≠ 0.
- start while busy=1 is ignored, with no queueing.
- rst has priority over everything, including mid-RUN. The next state is IDLE and the in-flight result is discarded.
- Reset values: busy=0, done=0, Quotient=0, Remainder=0, DivByZero=0, state IDLE.

## Timing
- Latency: start sampled at edge k → done high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles (5 at default).
- busy goes high the cycle after acceptance and low in the done cycle.
- Back-to-back: start asserted in the done cycle is accepted. The next done follows WIDTH+1 cycles later, giving a throughput of one operation per WIDTH+1 cycles.
- DivByZero updates in the done cycle and holds with the results.

## Configuration
- Macro: CLA_DIV_ZERO_DETECT_EN.
- Defined:
  - Divisor=0 at acceptance skips RUN and goes straight to DONE; done arrives 1 cycle after start.
  - Quotient = all ones, Remainder = Dividend, DivByZero=1.
- Undefined:
  - Divisor=0 runs the full WIDTH steps. The restoring algorithm naturally yields Quotient = all ones and Remainder = Dividend.
  - DivByZero stays constant 0.
- Numeric results are identical either way; only latency and the flag differ.

## Structure
- Package cla_div_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - the DEFAULT_WIDTH constant;
  - a clog2-based counter-width constant.
- Sub-module cla_subtractor (WIDTH+1 bits, combinational):
  - generate/propagate carry-lookahead over A + ~B + 1;
  - outputs difference and borrow (borrow = ~carry-out).
- Top level holds the FSM, the step counter, and the R/Q/D registers.

## Test plan
- Dividend=13, Divisor=4, start 1 cycle → done 5 cycles later, Quotient=3, Remainder=1, DivByZero=0.
- 15/1 → Quotient=15, Remainder=0. Then 7/9 → Quotient=0, Remainder=7. Exhaustive 4-bit sweep checks the invariant.
- 10/0 → with macro: done after 1 cycle, Quotient=15, Remainder=10, DivByZero=1. Without macro: done after 5 cycles, same values, DivByZero=0.
- Start 9/2; pulse start with 14/3 while busy → ignored; result Quotient=4, Remainder=1.
- rst asserted in the 3rd RUN cycle → next cycle busy=0, done=0, Quotient=0, Remainder=0. A new start of 6/3 completes with Quotient=2, Remainder=0.
- start held high through the done cycle with new operands 12/5 → second done exactly 5 cycles after the first, Quotient=2, Remainder=2.

Source files
------------

// File: rtl/cla_div_pkg.sv
// Shared types and constants for the restoring divider.
// The optional divide-by-zero shortcut is selected in the top level
// by the CLA_DIV_ZERO_DETECT_EN macro.
package cla_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

  // The step counter only has to hold WIDTH-1 down to 0.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/cla_subtractor.sv
// Combinational carry-lookahead subtractor: o_diff = i_a - i_b, computed
// as i_a + ~i_b + 1. o_borrow is high when i_b > i_a (no carry out).
module cla_subtractor #(
  parameter int N = 5
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_diff,
  output logic         o_borrow
);

  logic [N-1:0] w_g;
  logic [N-1:0] w_p;
  logic [N:0]   w_c;

  assign w_g = i_a & ~i_b;
  assign w_p = i_a ^ ~i_b;

  // Each carry is a flat sum of products: generate at bit j propagated
  // through bits j+1..i, plus the carry-in (1) propagated through 0..i.
  always_comb begin
    logic v_run;
    logic v_acc;
    w_c    = '0;
    w_c[0] = 1'b1;
    v_run  = 1'b1;
    v_acc  = 1'b0;
    for (int i = 0; i < N; i++) begin
      v_run = 1'b1;
      v_acc = 1'b0;
      for (int j = i; j >= 0; j--) begin
        v_acc = v_acc | (w_g[j] & v_run);
        v_run = v_run & w_p[j];
      end
      w_c[i+1] = v_acc | v_run;
    end
  end

  assign o_diff   = w_p ^ w_c[N-1:0];
  assign o_borrow = ~w_c[N];

endmodule

// File: rtl/cla_restoring_divider.sv
// Multi-cycle unsigned restoring divider with start/done handshake.
// One trial subtraction per RUN cycle through cla_subtractor.
// Optional macro CLA_DIV_ZERO_DETECT_EN: a zero divisor bypasses RUN and
// raises DivByZero; numeric results are the same in both builds.
module cla_restoring_divider
  import cla_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;

  logic             w_accept;
  logic             w_zero_skip;
  logic             w_last_step;
  logic [WIDTH:0]   w_trial_a;
  logic [WIDTH:0]   w_trial_b;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic             w_keep;

  assign w_accept    = start && (r_state != RUN);
  assign w_last_step = (r_state == RUN) && (r_cnt == '0);

`ifdef CLA_DIV_ZERO_DETECT_EN
  assign w_zero_skip = (Divisor == '0);
`else
  assign w_zero_skip = 1'b0;
`endif

  assign w_trial_a = {r_r, r_q[WIDTH-1]};
  assign w_trial_b = {1'b0, r_d};

  cla_subtractor #(
    .N (WIDTH + 1)
  ) u_sub (
    .i_a      (w_trial_a),
    .i_b      (w_trial_b),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  // A successful trial is always below the divisor, so its top bit is
  // zero; requiring it keeps the kept remainder provably in range.
  assign w_keep = ~w_borrow & ~w_diff[WIDTH];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = w_zero_skip ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_state_nxt = w_zero_skip ? DONE : RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, step counter and one restoring step per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      r_r   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_d   <= Divisor;
      r_cnt <= CNT_W'(WIDTH - 1);
      if (w_zero_skip) begin
        r_q <= '1;
        r_r <= Dividend;
      end else begin
        r_q <= Dividend;
        r_r <= '0;
      end
    end else if (r_state == RUN) begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_keep) begin
        r_r <= w_diff[WIDTH-1:0];
        r_q <= {r_q[WIDTH-2:0], 1'b1};
      end else begin
        r_r <= {r_r[WIDTH-2:0], r_q[WIDTH-1]};
        r_q <= {r_q[WIDTH-2:0], 1'b0};
      end
    end
  end

`ifdef CLA_DIV_ZERO_DETECT_EN
  logic r_dbz;

  // Flag is written only when an operation completes, so it holds with
  // the results through the following IDLE and the next RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dbz <= 1'b0;
    end else if (w_accept && w_zero_skip) begin
      r_dbz <= 1'b1;
    end else if (w_last_step) begin
      r_dbz <= 1'b0;
    end
  end

  assign DivByZero = r_dbz;
`else
  assign DivByZero = 1'b0;
`endif

  assign Quotient  = r_q;
  assign Remainder = r_r;

endmodule
